// File: rtl/frame_draw_sched.sv
// Per-frame draw scheduler: runs the BG, basket and egg engines in fixed order on each
// frame tick and muxes the active engine onto the single VGA adapter write port.
module frame_draw_sched #(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int C_W     = 3,
    parameter int TIMEOUT = 20000,
    parameter int TO_W    = 15
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           frame_tick,
    input  logic [2:0]     phase_mask,
    input  logic           bg_done,
    input  logic           bk_done,
    input  logic           eg_done,
    input  logic [X_W-1:0] bg_x,
    input  logic [X_W-1:0] bk_x,
    input  logic [X_W-1:0] eg_x,
    input  logic [Y_W-1:0] bg_y,
    input  logic [Y_W-1:0] bk_y,
    input  logic [Y_W-1:0] eg_y,
    input  logic [C_W-1:0] bg_c,
    input  logic [C_W-1:0] bk_c,
    input  logic [C_W-1:0] eg_c,
    output logic           bg_en,
    output logic           bk_en,
    output logic           eg_en,
    output logic [X_W-1:0] vga_x,
    output logic [Y_W-1:0] vga_y,
    output logic [C_W-1:0] vga_colour,
    output logic           vga_plot,
    output logic           busy,
    output logic           frame_done,
    output logic           overrun,
    output logic           timeout_err
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_BG   = 3'd1;
    localparam logic [2:0] S_BK   = 3'd2;
    localparam logic [2:0] S_EG   = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] WD_MAX  = '1;

    logic [2:0]      state, state_nx, mask_q;
    logic [TO_W-1:0] wd;
    logic            in_draw, act_done, wd_hit, leave;

    assign in_draw = (state == S_BG) || (state == S_BK) || (state == S_EG);
    assign wd_hit  = (wd == WD_LAST);
    assign leave   = act_done || wd_hit;

    // Only the engine owning the current phase can end it.
    always_comb begin
        act_done = 1'b0;
        case (state)
            S_BG:    act_done = bg_done;
            S_BK:    act_done = bk_done;
            S_EG:    act_done = eg_done;
            default: act_done = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (frame_tick)
                state_nx = phase_mask[0] ? S_BG : phase_mask[1] ? S_BK :
                           phase_mask[2] ? S_EG : S_FIN;
            S_BG:   if (leave) state_nx = mask_q[1] ? S_BK : mask_q[2] ? S_EG : S_FIN;
            S_BK:   if (leave) state_nx = mask_q[2] ? S_EG : S_FIN;
            S_EG:   if (leave) state_nx = S_FIN;
            S_FIN:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= S_IDLE;
            mask_q      <= '0;
            wd          <= '0;
            bg_en       <= 1'b0;
            bk_en       <= 1'b0;
            eg_en       <= 1'b0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
            vga_plot    <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && frame_tick) mask_q <= phase_mask;
            if (state_nx != state)                wd <= '0;
            else if (in_draw && wd != WD_MAX)     wd <= wd + TO_W'(1);
            // Enables rise the cycle after entry and fall together with the state change.
            bg_en      <= (state == S_BG) && (state_nx == S_BG);
            bk_en      <= (state == S_BK) && (state_nx == S_BK);
            eg_en      <= (state == S_EG) && (state_nx == S_EG);
            busy       <= (state_nx != S_IDLE);
            frame_done <= (state == S_FIN);
            if (frame_tick && state != S_IDLE)        overrun     <= 1'b1;
            if (in_draw && wd_hit && !act_done)       timeout_err <= 1'b1;
            // One register stage here covers the engines' pixel ROM latency.
            case (state)
                S_BG: begin
                    vga_x <= bg_x; vga_y <= bg_y; vga_colour <= bg_c; vga_plot <= bg_en;
                end
                S_BK: begin
                    vga_x <= bk_x; vga_y <= bk_y; vga_colour <= bk_c; vga_plot <= bk_en;
                end
                S_EG: begin
                    vga_x <= eg_x; vga_y <= eg_y; vga_colour <= eg_c; vga_plot <= eg_en;
                end
                default: vga_plot <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_draw_sched.sv
// Bench for frame_draw_sched: directed and random frames checked cycle by cycle against
// a timeline model built from phase durations.
module tb_frame_draw_sched;
    localparam int X_W = 8, Y_W = 7, C_W = 3, TIMEOUT = 16, TO_W = 15;

    logic clock = 1'b0, resetn = 1'b0, frame_tick = 1'b0;
    logic [2:0] phase_mask = '0;
    logic bg_done = 1'b0, bk_done = 1'b0, eg_done = 1'b0;
    logic [X_W-1:0] bg_x = '0, bk_x = '0, eg_x = '0;
    logic [Y_W-1:0] bg_y = '0, bk_y = '0, eg_y = '0;
    logic [C_W-1:0] bg_c = '0, bk_c = '0, eg_c = '0;
    logic bg_en, bk_en, eg_en, vga_plot, busy, frame_done, overrun, timeout_err;
    logic [X_W-1:0] vga_x;
    logic [Y_W-1:0] vga_y;
    logic [C_W-1:0] vga_colour;

    always #5 clock = ~clock;

    frame_draw_sched #(.X_W(X_W), .Y_W(Y_W), .C_W(C_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clock(clock), .resetn(resetn), .frame_tick(frame_tick), .phase_mask(phase_mask),
        .bg_done(bg_done), .bk_done(bk_done), .eg_done(eg_done),
        .bg_x(bg_x), .bk_x(bk_x), .eg_x(eg_x), .bg_y(bg_y), .bk_y(bk_y), .eg_y(eg_y),
        .bg_c(bg_c), .bk_c(bk_c), .eg_c(eg_c),
        .bg_en(bg_en), .bk_en(bk_en), .eg_en(eg_en),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .busy(busy), .frame_done(frame_done), .overrun(overrun), .timeout_err(timeout_err)
    );

    int n_tests = 0, n_fail = 0, frame_no = 0;
    bit pending_done = 0, ovr_next = 0, exp_ovr = 0, exp_to = 0;
    logic [X_W-1:0] hx = '0;
    logic [Y_W-1:0] hy = '0;
    logic [C_W-1:0] hc = '0;
    logic [X_W-1:0] px [3];
    logic [Y_W-1:0] py [3];
    logic [C_W-1:0] pc [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle(input string tag, input logic [2:0] e_en, input bit e_busy,
                               input bit e_fd, input bit e_plot);
        chk($sformatf("%s.en", tag), 32'({eg_en, bk_en, bg_en}), 32'(e_en));
        chk($sformatf("%s.busy", tag), 32'(busy), 32'(e_busy));
        chk($sformatf("%s.frame_done", tag), 32'(frame_done), 32'(e_fd));
        chk($sformatf("%s.plot", tag), 32'(vga_plot), 32'(e_plot));
        chk($sformatf("%s.pix", tag), 32'({vga_colour, vga_y, vga_x}), 32'({hc, hy, hx}));
        chk($sformatf("%s.overrun", tag), 32'(overrun), 32'(exp_ovr));
        chk($sformatf("%s.timeout_err", tag), 32'(timeout_err), 32'(exp_to));
    endtask

    task automatic drive_pix();
        for (int p = 0; p < 3; p++) begin
            px[p] = X_W'($urandom);
            py[p] = Y_W'($urandom);
            pc[p] = C_W'($urandom);
        end
        bg_x = px[0]; bk_x = px[1]; eg_x = px[2];
        bg_y = py[0]; bk_y = py[1]; eg_y = py[2];
        bg_c = pc[0]; bk_c = pc[1]; eg_c = pc[2];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (ovr_next) begin exp_ovr = 1; ovr_next = 0; end
            check_cycle($sformatf("idle%0d", frame_no), 3'b000, 0, pending_done, 0);
            pending_done = 0;
            frame_tick = 0; bg_done = 0; bk_done = 0; eg_done = 0;
            phase_mask = 3'($urandom);
            drive_pix();
        end
    endtask

    // d[p]: enabled cycles before engine p pulses done (>= TIMEOUT means it never does).
    // ovr_in / stray_in: cycle of an extra tick / stray eg_done, -1 none, -2 random.
    task automatic run_frame(input logic [2:0] m, input int d0, input int d1, input int d2,
                             input int ovr_in, input int stray_in);
        int d [3];
        int entry [3];
        int len [3];
        bit tmo [3];
        int fin, ovr_at, stray_at, c;
        logic [2:0] e_en;
        bit e_plot;
        d[0] = d0; d[1] = d1; d[2] = d2;
        c = 1;
        for (int p = 0; p < 3; p++) begin
            tmo[p] = 0; entry[p] = -1; len[p] = 0;
            if (m[p]) begin
                entry[p] = c;
                tmo[p]   = (d[p] >= TIMEOUT);
                len[p]   = tmo[p] ? TIMEOUT : d[p] + 1;
                c += len[p];
            end
        end
        fin = c;
        ovr_at = (ovr_in == -2) ? int'($urandom_range(fin, 1)) : ovr_in;
        if (stray_in == -2) stray_at = m[0] ? int'($urandom_range(entry[0] + len[0] - 1, entry[0])) : -1;
        else                stray_at = stray_in;
        frame_no++;
        for (int cyc = 0; cyc <= fin; cyc++) begin
            @(negedge clock);
            if (ovr_next) begin exp_ovr = 1; ovr_next = 0; end
            e_en = '0; e_plot = 0;
            for (int p = 0; p < 3; p++) if (entry[p] >= 0) begin
                if (cyc > entry[p] && cyc < entry[p] + len[p]) e_en[p] = 1'b1;
                if (cyc - 1 > entry[p] && cyc - 1 < entry[p] + len[p]) e_plot = 1;
                if (cyc - 1 >= entry[p] && cyc - 1 < entry[p] + len[p]) begin
                    hx = px[p]; hy = py[p]; hc = pc[p];
                end
                if (tmo[p] && cyc == entry[p] + len[p]) exp_to = 1;
            end
            check_cycle($sformatf("f%0d.c%0d", frame_no, cyc), e_en, (cyc >= 1 && cyc <= fin),
                        (cyc == 0 && pending_done), e_plot);
            pending_done = 0;
            frame_tick = (cyc == 0) || (cyc == ovr_at);
            if (cyc == ovr_at) ovr_next = 1;
            phase_mask = (cyc == 0) ? m : 3'($urandom);
            bg_done = m[0] && !tmo[0] && (cyc == entry[0] + d[0]);
            bk_done = m[1] && !tmo[1] && (cyc == entry[1] + d[1]);
            eg_done = (m[2] && !tmo[2] && (cyc == entry[2] + d[2])) || (cyc == stray_at);
            drive_pix();
        end
        pending_done = 1;
    endtask

    initial begin
        drive_pix();
        repeat (3) @(negedge clock);
        check_cycle("reset", 3'b000, 0, 0, 0);
        resetn = 1;
        idle(2);
        // Full frame, then a back-to-back frame skipping BASKET, accepted on the done cycle.
        run_frame(3'b111, 5, 3, 4, -1, -1);
        run_frame(3'b101, 2, 7, 3, -1, -1);
        idle(2);
        run_frame(3'b000, 1, 1, 1, -1, -1);
        idle(2);
        // Stray eg_done during BG; egg done exactly on the watchdog limit.
        run_frame(3'b101, 6, 1, TIMEOUT - 1, -1, 3);
        idle(2);
        // Extra tick during EGG, then one during the FIN cycle.
        run_frame(3'b111, 2, 2, 5, 9, -1);
        idle(3);
        run_frame(3'b010, 3, 3, 3, 5, -1);
        idle(2);
        // Reset held mid-BG.
        @(negedge clock); frame_tick = 1; phase_mask = 3'b111;
        @(negedge clock); frame_tick = 0;
        @(negedge clock); chk("t1.bg_en", 32'(bg_en), 32'd1); resetn = 0;
        repeat (4) begin
            @(negedge clock);
            chk("t1.zero", 32'({bg_en, bk_en, eg_en, busy, frame_done, vga_plot, overrun,
                                timeout_err, vga_x, vga_y, vga_colour}), 32'd0);
        end
        resetn = 1;
        exp_ovr = 0; exp_to = 0; ovr_next = 0; pending_done = 0;
        hx = '0; hy = '0; hc = '0;
        idle(3);
        // BASKET never finishes: watchdog abort, then EGG still runs.
        run_frame(3'b111, 2, 1000, 3, -1, -1);
        idle(2);
        for (int i = 0; i < 25; i++) begin
            run_frame(3'($urandom), int'($urandom_range(18, 1)), int'($urandom_range(18, 1)),
                      int'($urandom_range(18, 1)), ($urandom_range(3, 0) == 0) ? -2 : -1,
                      ($urandom_range(1, 0) == 0) ? -2 : -1);
            if ($urandom_range(1, 0) == 1) idle(int'($urandom_range(3, 1)));
        end
        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
